// File: rtl/fmul_pkg.sv
// Shared FPU definitions: binary32 field widths, special encodings and the
// operand class used by the multiply datapath.
package fmul_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;

  localparam logic [31:0]      QNAN    = 32'h7FC0_0000;
  localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;

  typedef enum logic [1:0] {
    ZERO   = 2'd0,
    NORMAL = 2'd1,
    INF    = 2'd2,
    NAN    = 2'd3
  } fp_class_e;

  typedef struct packed {
    logic      sign;
    fp_class_e cls;
  } fp_op_t;

endpackage

// File: rtl/fp_classify.sv
// Decodes one binary32 operand into sign plus class; subnormals are reported
// as ZERO so they flush with their sign preserved.
module fp_classify
  import fmul_pkg::*;
(
  input  logic              sign,
  input  logic [EXP_W-1:0]  exp,
  input  logic [FRAC_W-1:0] frac,
  output fp_op_t            op
);

  // Class decode from the exponent and fraction fields
  always_comb begin
    op.sign = sign;
    op.cls  = NORMAL;
    if (exp == EXP_INF) begin
      if (frac != {FRAC_W{1'b0}}) begin
        op.cls = NAN;
      end else begin
        op.cls = INF;
      end
    end else if (exp == {EXP_W{1'b0}}) begin
      op.cls = ZERO;
    end else begin
      op.cls = NORMAL;
    end
  end

endmodule

// File: rtl/fmul.sv
// Binary32 multiplier: combinational classify/multiply/round feeding a single
// output register bank (latency 1, one operation per cycle).
module fmul
  import fmul_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              A_sign,
  input  logic [EXP_W-1:0]  A_exp,
  input  logic [FRAC_W-1:0] A_frac,
  input  logic              B_sign,
  input  logic [EXP_W-1:0]  B_exp,
  input  logic [FRAC_W-1:0] B_frac,
  output logic              sign,
  output logic [EXP_W-1:0]  exp,
  output logic [FRAC_W:0]   frac,
  output logic              error,
  output logic              overflow
);

  fp_op_t op_a_s;
  fp_op_t op_b_s;

  fp_classify u_cls_a (.sign(A_sign), .exp(A_exp), .frac(A_frac), .op(op_a_s));
  fp_classify u_cls_b (.sign(B_sign), .exp(B_exp), .frac(B_frac), .op(op_b_s));

  logic [47:0]       prod_s;
  logic [22:0]       mant_s;
  logic              guard_s;
  logic              sticky_s;
  logic              round_up_s;
  logic              carry_s;
  logic [22:0]       frac_fin_s;
  logic signed [9:0] exp_raw_s;
  logic signed [9:0] exp_fin_s;
  logic              nan_case_s;
  logic              inf_case_s;
  logic              zero_case_s;

  logic              sign_nx_s;
  logic [EXP_W-1:0]  exp_nx_s;
  logic [FRAC_W:0]   frac_nx_s;
  logic              error_nx_s;
  logic              ovf_nx_s;

  logic              sign_r;
  logic [EXP_W-1:0]  exp_r;
  logic [FRAC_W:0]   frac_r;
  logic              error_r;
  logic              ovf_r;

  assign prod_s = 48'({1'b1, A_frac}) * 48'({1'b1, B_frac});

  // Normalize the 48-bit product and round to nearest, ties to even
  always_comb begin
    if (prod_s[47]) begin
      mant_s   = prod_s[46:24];
      guard_s  = prod_s[23];
      sticky_s = |prod_s[22:0];
    end else begin
      mant_s   = prod_s[45:23];
      guard_s  = prod_s[22];
      sticky_s = |prod_s[21:0];
    end
    round_up_s = guard_s & (sticky_s | mant_s[0]);
    // An all-ones fraction that rounds up wraps to 0 and bumps the exponent
    carry_s    = round_up_s & (&mant_s);
    frac_fin_s = mant_s + {22'd0, round_up_s};
    exp_raw_s  = {2'b00, A_exp} + {2'b00, B_exp} - 10'(BIAS) + {9'd0, prod_s[47]};
    exp_fin_s  = exp_raw_s + {9'd0, carry_s};
  end

  assign nan_case_s  = (op_a_s.cls == NAN) || (op_b_s.cls == NAN) ||
                       ((op_a_s.cls == INF) && (op_b_s.cls == ZERO)) ||
                       ((op_b_s.cls == INF) && (op_a_s.cls == ZERO));
  assign inf_case_s  = (op_a_s.cls == INF) || (op_b_s.cls == INF);
  assign zero_case_s = (op_a_s.cls == ZERO) || (op_b_s.cls == ZERO);

  // Result selection in priority order: NaN, Inf, zero, then the datapath
  always_comb begin
    sign_nx_s  = op_a_s.sign ^ op_b_s.sign;
    exp_nx_s   = {EXP_W{1'b0}};
    frac_nx_s  = {(FRAC_W+1){1'b0}};
    error_nx_s = 1'b0;
    ovf_nx_s   = 1'b0;
    if (nan_case_s) begin
      sign_nx_s  = QNAN[31];
      exp_nx_s   = QNAN[30:23];
      frac_nx_s  = {QNAN[22:0], 1'b0};
      error_nx_s = 1'b1;
    end else if (inf_case_s) begin
      exp_nx_s = EXP_INF;
    end else if (zero_case_s) begin
      exp_nx_s = {EXP_W{1'b0}};
    end else if (exp_fin_s >= 10'sd255) begin
      exp_nx_s = EXP_INF;
      ovf_nx_s = 1'b1;
    end else if (exp_fin_s <= 10'sd0) begin
      exp_nx_s = {EXP_W{1'b0}};
    end else begin
      exp_nx_s  = exp_fin_s[7:0];
      frac_nx_s = {frac_fin_s, guard_s};
    end
  end

  // Output register bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_r  <= 1'b0;
      exp_r   <= {EXP_W{1'b0}};
      frac_r  <= {(FRAC_W+1){1'b0}};
      error_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      sign_r  <= sign_nx_s;
      exp_r   <= exp_nx_s;
      frac_r  <= frac_nx_s;
      error_r <= error_nx_s;
      ovf_r   <= ovf_nx_s;
    end
  end

  assign sign     = sign_r;
  assign exp      = exp_r;
  assign frac     = frac_r;
  assign error    = error_r;
  assign overflow = ovf_r;

endmodule

// File: tb/tb_fmul.sv
// Self-checking bench for fmul: directed vectors, reset/latency checks and
// randomized operands against an integer-arithmetic reference model.
module tb_fmul;

  logic        clk;
  logic        rst_n;
  logic        A_sign, B_sign;
  logic [7:0]  A_exp, B_exp;
  logic [22:0] A_frac, B_frac;
  logic        y_sign;
  logic [7:0]  y_exp;
  logic [23:0] y_frac;
  logic        y_error;
  logic        y_overflow;

  int n_cmp = 0;
  int n_bad = 0;
  logic [34:0] prev_q;

  fmul dut (
    .clk(clk), .rst_n(rst_n),
    .A_sign(A_sign), .A_exp(A_exp), .A_frac(A_frac),
    .B_sign(B_sign), .B_exp(B_exp), .B_frac(B_frac),
    .sign(y_sign), .exp(y_exp), .frac(y_frac),
    .error(y_error), .overflow(y_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed word: {R[31:0], round bit, error, overflow}
  function automatic logic [34:0] out_word();
    return {y_sign, y_exp, y_frac[23:1], y_frac[0], y_error, y_overflow};
  endfunction

  task automatic check_eq(input string tag, input logic [34:0] got, input logic [34:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got R=%h rnd/err/ovf=%b, want R=%h rnd/err/ovf=%b",
               tag, got[34:3], got[2:0], want[34:3], want[2:0]);
    end
  endtask

  // Reference: exact integer product, rounded by remainder comparison
  function automatic logic [34:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int ea, eb, e, msb, sh;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, g;
    longint unsigned p, q, rem, half;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    a_nan  = (ea == 255) && (a[22:0] != 23'd0);
    b_nan  = (eb == 255) && (b[22:0] != 23'd0);
    a_inf  = (ea == 255) && (a[22:0] == 23'd0);
    b_inf  = (eb == 255) && (b[22:0] == 23'd0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    s = a[31] ^ b[31];
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return {32'h7FC00000, 3'b010};
    if (a_inf || b_inf) return {s, 8'hFF, 23'd0, 3'b000};
    if (a_zero || b_zero) return {s, 31'd0, 3'b000};
    p = (64'(a[22:0]) + (64'd1 << 23)) * (64'(b[22:0]) + (64'd1 << 23));
    msb = 47;
    while (p[msb] == 1'b0) msb--;
    sh   = msb - 23;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    g    = (rem >= half);
    if ((rem > half) || ((rem == half) && q[0])) q++;
    e = ea + eb - 127 + (msb - 46);
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e++;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0, 3'b001};
    if (e <= 0) return {s, 31'd0, 3'b000};
    return {s, 8'(e), q[22:0], g, 2'b00};
  endfunction

  function automatic logic [31:0] rnd_op();
    int k;
    logic [7:0] e;
    logic [22:0] f;
    k = int'($urandom_range(0, 19));
    e = 8'($urandom_range(1, 254));
    f = 23'($urandom);
    case (k)
      0: e = 8'h00;
      1: e = 8'hFF;
      2: begin e = 8'hFF; f = 23'd0; end
      3: f = 23'h7FFFFF;
      4: f = 23'd0;
      5: f = 23'd1;
      6: e = 8'($urandom_range(180, 254));
      7: e = 8'($urandom_range(1, 70));
      default: e = e;
    endcase
    return {1'($urandom), e, f};
  endfunction

  // Apply one operand pair; the old result must hold until the next edge
  task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [34:0] want);
    {A_sign, A_exp, A_frac} = a;
    {B_sign, B_exp, B_frac} = b;
    #1;
    check_eq({tag, "/hold"}, out_word(), prev_q);
    @(posedge clk);
    #1;
    check_eq(tag, out_word(), want);
    prev_q = want;
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst_n = 1'b0;
    {A_sign, A_exp, A_frac} = 32'hC3700000;
    {B_sign, B_exp, B_frac} = 32'hC2F00000;
    prev_q = 35'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset", out_word(), 35'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_vec("mul_neg",  32'hC3700000, 32'hC2F00000, {32'h46E10000, 3'b000});
    run_vec("exact",    32'h40008000, 32'h40808000, {32'h41010080, 3'b000});
    run_vec("tie_even", 32'h3F800001, 32'h3FC00000, {32'h3FC00002, 3'b100});
    run_vec("inf_inf",  32'h7F800000, 32'hFF800000, {32'hFF800000, 3'b000});
    run_vec("inf_zero", 32'h7F800000, 32'h00000000, {32'h7FC00000, 3'b010});
    run_vec("nan_op",   32'hFFC00000, 32'hC3700000, {32'h7FC00000, 3'b010});
    run_vec("ovf",      32'h7F000000, 32'h7F000000, {32'h7F800000, 3'b001});
    run_vec("unf",      32'h00800000, 32'h00800000, {32'h00000000, 3'b000});
    run_vec("rnd_carry", 32'h3FFFFFFF, 32'h3F800001, ref_mul(32'h3FFFFFFF, 32'h3F800001));

    for (int i = 0; i < 400; i++) begin
      ra = rnd_op();
      rb = rnd_op();
      run_vec("random", ra, rb, ref_mul(ra, rb));
    end

    // Reset in the middle of an operation discards the in-flight result
    {A_sign, A_exp, A_frac} = 32'h40400000;
    {B_sign, B_exp, B_frac} = 32'h40400000;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_reset", out_word(), 35'd0);
    @(posedge clk);
    #1;
    check_eq("mid_reset_hold", out_word(), 35'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_q = 35'd0;
    run_vec("post_reset", 32'h40400000, 32'h40400000, {32'h41100000, 3'b000});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
